mic_stream_sched: RTL and testbench
===================================

MIC_STREAM_SCHED -- requirements
Module: mic_stream_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of stereo frames buffered (power of two, 2..16).
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, the first byte of each stream packet.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock. All logic is in this domain.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable_i, input, 1 bit: sample streaming enable.
REQ-006 SHALL have port decim_i, input, 4 bits: keep one frame in every decim_i+1 strobes.
REQ-007 SHALL have port sample_stb_i, input, 1 bit: one-cycle strobe marking a new stereo frame.
REQ-008 SHALL have ports left_i and right_i, input, 24 bits each: signed samples, valid while sample_stb_i is high.
REQ-009 SHALL have ports rsp_valid_i (in, 1), rsp_data_i (in, 8), rsp_last_i (in, 1) and rsp_ready_o (out, 1): the command-response byte requester.
REQ-010 SHALL have ports tx_valid_o (out, 1), tx_data_o (out, 8) and tx_ready_i (in, 1): the shared UART TX byte port.
REQ-011 SHALL have port overflow_o, output, 1 bit: sticky flag set when a frame is dropped.
REQ-012 SHALL have port fifo_level_o, output, $clog2(FIFO_DEPTH)+1 bits: the number of buffered frames.
REQ-013 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 Decimation counter SHALL count sample_stb_i pulses while enable_i=1, with wrap-around:
- a frame is "kept" when the counter is 0;
- the counter is held at 0 while enable_i=0.
REQ-015 Each kept frame SHALL increment the 8-bit sequence counter seq, wrapping from 255 to 0, whether or not the frame is stored.
REQ-016 A kept frame SHALL be pushed as {seq, left_i, right_i} when the FIFO is not full; when full, it SHALL be dropped and overflow_o set to 1.
REQ-017 Simultaneous push and pop when the FIFO is full SHALL accept the push; fifo_level_o is unchanged.
REQ-018 The state machine SHALL have states IDLE, RSP and STRM, and SHALL arbitrate only at packet boundaries.
REQ-019 In IDLE, the state machine SHALL grant round-robin on the next cycle:
- rsp_valid_i=1 and FIFO non-empty: grant the requester not granted last; after reset, RSP wins;
- only one request present: grant that one;
- neither: stay in IDLE.
REQ-020 In RSP, the port SHALL pass through combinationally:
- tx_valid_o=rsp_valid_i, tx_data_o=rsp_data_i, rsp_ready_o=tx_ready_i;
- return to IDLE after a handshake with rsp_last_i=1.
REQ-021 In STRM, tx_valid_o SHALL be 1 and tx_data_o SHALL present, in order: HDR_BYTE, seq, L[23:16], L[15:8], L[7:0], R[23:16], R[15:8], R[7:0].
REQ-022 In STRM, the byte index SHALL advance only on tx_valid_o & tx_ready_i; the last handshake SHALL pop the FIFO and return to IDLE.
REQ-023 Outside RSP, rsp_ready_o SHALL be 0; in IDLE, tx_valid_o SHALL be 0.
REQ-024 tx_data_o SHALL stay stable while tx_valid_o=1 and tx_ready_i=0.
REQ-025 Deasserting enable_i mid-packet SHALL NOT abort the packet; buffered frames SHALL continue to drain.
REQ-026 A response burst SHALL never be interleaved with stream bytes, and stream bytes SHALL never be interleaved with a response burst.

Reset
REQ-027 While rst_i=1, the block SHALL hold the following reset values:
- state IDLE;
- FIFO empty, fifo_level_o=0;
- seq=0, decimation counter 0, byte index 0;
- last-grant = STRM;
- overflow_o=0, busy_o=0, tx_valid_o=0, rsp_ready_o=0, tx_data_o=0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet; tx_valid_o SHALL be 0 on the cycle after rst_i is sampled high.

Configuration
REQ-029 When macro MIC_STREAM_CHECKSUM_EN is defined, STRM SHALL send a 9th byte: the XOR of bytes 2..8 (seq through R[7:0]). The pop SHALL then occur on the 9th handshake.
REQ-030 When MIC_STREAM_CHECKSUM_EN is undefined, packets SHALL be 8 bytes with no checksum logic.

Verification
REQ-031 Stream packet: enable_i=1, decim_i=0, one strobe with L=24'h123456, R=24'hABCDEF, tx_ready_i=1 -> bytes A5 00 12 34 56 AB CD EF; with the checksum macro, a 9th byte 0x00^12^34^56^AB^CD^EF.
REQ-032 Decimation: decim_i=2, 9 strobes -> 3 packets with seq 0, 1, 2.
REQ-033 Overflow: tx_ready_i=0, 6 kept strobes with FIFO_DEPTH=4 -> fifo_level_o=4 and overflow_o=1. After releasing tx_ready_i, the packet seqs are 0, 1, 2, 3; the later packets carry seq 4 and 5 only if their frames were stored.
REQ-034 Arbitration: 3-byte response (last on byte 3) and a FIFO frame pending in the same IDLE cycle after reset -> the 3 response bytes are sent first, then the 8 stream bytes, with no interleave.
REQ-035 Backpressure: toggle tx_ready_i every cycle during STRM -> tx_data_o is held stable while unaccepted, and the byte order is correct.
REQ-036 Reset mid-packet: rst_i for 1 cycle after byte 4 -> the next cycle has tx_valid_o=0 and fifo_level_o=0; the next packet has seq 00.

Source files
------------

// File: rtl/mic_stream_sched.sv
// Stereo mic frame decimator + FIFO + byte scheduler sharing one UART TX port with a response requester.
// Define MIC_STREAM_CHECKSUM_EN to append an XOR checksum byte to every stream packet.
module mic_stream_sched #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [3:0]                  decim_i,
  input  logic                        sample_stb_i,
  input  logic [23:0]                 left_i,
  input  logic [23:0]                 right_i,
  input  logic                        rsp_valid_i,
  input  logic [7:0]                  rsp_data_i,
  input  logic                        rsp_last_i,
  output logic                        rsp_ready_o,
  output logic                        tx_valid_o,
  output logic [7:0]                  tx_data_o,
  input  logic                        tx_ready_i,
  output logic                        overflow_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef MIC_STREAM_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RSP, S_STRM} state_t;

  state_t          state_q, state_d;
  logic            last_strm_q, last_strm_d;
  logic [3:0]      dec_cnt_q, dec_cnt_d;
  logic [7:0]      seq_q, seq_d;
  logic [3:0]      idx_q, idx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [55:0]     fifo_mem [FIFO_DEPTH];

  logic            kept, full, nempty, push, pop, strm_hs;
  logic [7:0]      h_seq;
  logic [23:0]     h_l, h_r;

  assign {h_seq, h_l, h_r} = fifo_mem[rd_ptr_q];
  assign kept    = enable_i & sample_stb_i & (dec_cnt_q == 4'd0);
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign nempty  = (level_q != '0);
  assign strm_hs = (state_q == S_STRM) & tx_ready_i;
  assign pop     = strm_hs & (idx_q == LAST_IDX);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push    = kept & (~full | pop);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      last_strm_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      last_strm_q <= last_strm_d;
    end
  end

  // Next-state: arbitration happens only from IDLE, i.e. at packet boundaries.
  always_comb begin
    state_d     = state_q;
    last_strm_d = last_strm_q;
    case (state_q)
      S_IDLE: begin
        if (rsp_valid_i && nempty) begin
          state_d     = last_strm_q ? S_RSP : S_STRM;
          last_strm_d = ~last_strm_q;
        end else if (rsp_valid_i) begin
          state_d     = S_RSP;
          last_strm_d = 1'b0;
        end else if (nempty) begin
          state_d     = S_STRM;
          last_strm_d = 1'b1;
        end
      end
      S_RSP:  if (rsp_valid_i && tx_ready_i && rsp_last_i) state_d = S_IDLE;
      S_STRM: if (pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    rsp_ready_o = 1'b0;
    case (state_q)
      S_RSP: begin
        tx_valid_o  = rsp_valid_i;
        tx_data_o   = rsp_data_i;
        rsp_ready_o = tx_ready_i;
      end
      S_STRM: begin
        tx_valid_o = 1'b1;
        case (idx_q)
          4'd0:    tx_data_o = HDR_BYTE;
          4'd1:    tx_data_o = h_seq;
          4'd2:    tx_data_o = h_l[23:16];
          4'd3:    tx_data_o = h_l[15:8];
          4'd4:    tx_data_o = h_l[7:0];
          4'd5:    tx_data_o = h_r[23:16];
          4'd6:    tx_data_o = h_r[15:8];
          4'd7:    tx_data_o = h_r[7:0];
`ifdef MIC_STREAM_CHECKSUM_EN
          4'd8:    tx_data_o = h_seq ^ h_l[23:16] ^ h_l[15:8] ^ h_l[7:0]
                             ^ h_r[23:16] ^ h_r[15:8] ^ h_r[7:0];
`endif
          default: tx_data_o = 8'h00;
        endcase
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign overflow_o   = overflow_q;
  assign fifo_level_o = level_q;

  // Datapath next values: decimation, sequence, FIFO pointers, byte index.
  always_comb begin
    dec_cnt_d  = dec_cnt_q;
    seq_d      = seq_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    idx_d      = idx_q;
    if (!enable_i)         dec_cnt_d = 4'd0;
    else if (sample_stb_i) dec_cnt_d = (dec_cnt_q >= decim_i) ? 4'd0 : dec_cnt_q + 4'd1;
    if (kept)              seq_d = seq_q + 8'd1;
    if (kept && !push)     overflow_d = 1'b1;
    if (push)              wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)               rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (state_q != S_STRM) idx_d = 4'd0;
    else if (strm_hs)      idx_d = pop ? 4'd0 : idx_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_cnt_q  <= 4'd0;
      seq_q      <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      idx_q      <= 4'd0;
    end else begin
      dec_cnt_q  <= dec_cnt_d;
      seq_q      <= seq_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      idx_q      <= idx_d;
    end
  end

  // Frame storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= {seq_q, left_i, right_i};
  end
endmodule

// File: tb/tb_mic_stream_sched.sv
// Self-checking bench for mic_stream_sched: random frames against a packet-level reference model.
module tb_mic_stream_sched;
  logic        clk_i = 1'b0;
  logic        rst_i, enable_i, sample_stb_i;
  logic [3:0]  decim_i;
  logic [23:0] left_i, right_i;
  logic        rsp_valid_i, rsp_last_i, rsp_ready_o;
  logic [7:0]  rsp_data_i;
  logic        tx_valid_o, tx_ready_i;
  logic [7:0]  tx_data_o;
  logic        overflow_o, busy_o;
  logic [2:0]  fifo_level_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  bit         pend;
  logic [7:0] pend_data;

  always #5 clk_i = ~clk_i;

  mic_stream_sched #(.FIFO_DEPTH(4), .HDR_BYTE(8'hA5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .decim_i(decim_i),
    .sample_stb_i(sample_stb_i), .left_i(left_i), .right_i(right_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_last_i(rsp_last_i),
    .rsp_ready_o(rsp_ready_o), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
    .tx_ready_i(tx_ready_i), .overflow_o(overflow_o), .fifo_level_o(fifo_level_o),
    .busy_o(busy_o)
  );

  // Byte monitor: records accepted TX bytes and checks data holds while stalled.
  always @(negedge clk_i) begin
    if (rst_i) begin
      pend = 1'b0;
    end else begin
      if (pend && tx_valid_o) begin
        checks++;
        if (tx_data_o !== pend_data) begin
          errors++;
          $display("FAIL hold_stable tx_data=%02h required %02h", tx_data_o, pend_data);
        end
      end
      if (tx_valid_o && tx_ready_i) cap_q.push_back(tx_data_o);
      pend      = tx_valid_o && !tx_ready_i;
      pend_data = tx_data_o;
    end
  end

  // Reference packet: header, seq, L and R big-endian, optional XOR checksum.
  function automatic void add_pkt(input logic [7:0] s, input logic [23:0] l, input logic [23:0] r);
    logic [7:0] c;
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    for (int k = 2; k >= 0; k--) exp_q.push_back(l[k*8 +: 8]);
    for (int k = 2; k >= 0; k--) exp_q.push_back(r[k*8 +: 8]);
    c = s ^ l[23:16] ^ l[15:8] ^ l[7:0] ^ r[23:16] ^ r[15:8] ^ r[7:0];
`ifdef MIC_STREAM_CHECKSUM_EN
    exp_q.push_back(c);
`else
    if (c === 8'hxx) exp_q.push_back(8'h00);
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1; enable_i = 1'b0; decim_i = 4'd0; sample_stb_i = 1'b0;
    left_i = '0; right_i = '0; rsp_valid_i = 1'b0; rsp_data_i = 8'h00;
    rsp_last_i = 1'b0; tx_ready_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    cap_q.delete(); exp_q.delete();
  endtask

  task automatic strobe(input logic [23:0] l, input logic [23:0] r);
    sample_stb_i = 1'b1; left_i = l; right_i = r;
    tick();
    sample_stb_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((fifo_level_o != 3'd0 || busy_o) && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout level=%0d busy=%0b required level 0 and idle", name, fifo_level_o, busy_o);
    end
    tick();
  endtask

  // Response requester: 3 bytes, optionally with a frame strobed one cycle earlier.
  task automatic run_rsp(input logic [7:0] r0, r1, r2, input bit with_frame, input logic [23:0] l, r);
    logic [7:0] rb [3];
    int idx = 0;
    int n = 0;
    bit hs;
    rb[0] = r0; rb[1] = r1; rb[2] = r2;
    if (with_frame) strobe(l, r); else tick();
    rsp_valid_i = 1'b1; rsp_data_i = rb[0]; rsp_last_i = 1'b0;
    while (idx < 3 && n < 60) begin
      hs = rsp_ready_o && rsp_valid_i;
      tick();
      if (hs) idx++;
      if (idx < 3) begin rsp_data_i = rb[idx]; rsp_last_i = (idx == 2); end
      else begin rsp_valid_i = 1'b0; rsp_last_i = 1'b0; end
      n++;
    end
    if (idx < 3) begin
      checks++; errors++;
      $display("FAIL rsp_timeout sent=%0d required 3", idx);
      rsp_valid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    rst_i = 1'b1; tick();
    checks += 6;
    if (fifo_level_o !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d required 0", fifo_level_o); end
    if (overflow_o !== 1'b0)   begin errors++; $display("FAIL rst_overflow got=%0b required 0", overflow_o); end
    if (busy_o !== 1'b0)       begin errors++; $display("FAIL rst_busy got=%0b required 0", busy_o); end
    if (tx_valid_o !== 1'b0)   begin errors++; $display("FAIL rst_tx_valid got=%0b required 0", tx_valid_o); end
    if (rsp_ready_o !== 1'b0)  begin errors++; $display("FAIL rst_rsp_ready got=%0b required 0", rsp_ready_o); end
    if (tx_data_o !== 8'h00)   begin errors++; $display("FAIL rst_tx_data got=%02h required 00", tx_data_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_stream_basic();
    apply_reset();
    enable_i = 1'b1; tx_ready_i = 1'b1;
    strobe(24'h123456, 24'hABCDEF);
    add_pkt(8'h00, 24'h123456, 24'hABCDEF);
    wait_drain(100, "basic");
    checks++;
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_len got=%0d required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d got=%02h required %02h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_decim();
    int kept = 0;
    logic [23:0] l, r;
    apply_reset();
    enable_i = 1'b1; decim_i = 4'd2; tx_ready_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      l = 24'($urandom()); r = 24'($urandom());
      strobe(l, r);
      if (k % 3 == 0) begin add_pkt(8'(kept), l, r); kept++; end
      repeat (11) tick();
    end
    wait_drain(100, "decim");
    checks++;
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL decim_len got=%0d required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL decim_byte%0d got=%02h required %02h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int kept = 0;
    int d;
    logic [23:0] l, r;
    apply_reset();
    d = $urandom_range(0, 3);
    enable_i = 1'b1; decim_i = 4'(d);
    for (int k = 0; k < 10; k++) begin
      l = 24'($urandom()); r = 24'($urandom());
      tx_ready_i = 1'($urandom());
      strobe(l, r);
      if (k % (d + 1) == 0) begin add_pkt(8'(kept), l, r); kept++; end
      for (int c = 0; c < 39; c++) begin tx_ready_i = 1'($urandom()); tick(); end
    end
    tx_ready_i = 1'b1;
    wait_drain(200, "random");
    checks += 2;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL random_overflow got=%0b required 0", overflow_o); end
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_len decim=%0d got=%0d required %0d", d, cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_byte%0d got=%02h required %02h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [23:0] la, ra, lb, rb;
    apply_reset();
    la = 24'($urandom()); ra = 24'($urandom()); lb = 24'($urandom()); rb = 24'($urandom());
    enable_i = 1'b1;
    strobe(la, ra);
    strobe(lb, rb);
    add_pkt(8'h00, la, ra);
    add_pkt(8'h01, lb, rb);
    enable_i = 1'b0;
    strobe(24'h0F0F0F, 24'hF0F0F0);
    while ((fifo_level_o != 3'd0 || busy_o) && n < 200) begin tx_ready_i = ~tx_ready_i; tick(); n++; end
    if (n >= 200) begin checks++; errors++; $display("FAIL bp_timeout level=%0d required 0", fifo_level_o); end
    tick();
    checks++;
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_len got=%0d required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d got=%02h required %02h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] l, r;
    apply_reset();
    enable_i = 1'b1; tx_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      l = 24'($urandom()); r = 24'($urandom());
      strobe(l, r);
      tick();
      if (k < 4) add_pkt(8'(k), l, r);
    end
    checks += 2;
    if (fifo_level_o !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d required 4", fifo_level_o); end
    if (overflow_o !== 1'b1)   begin errors++; $display("FAIL ovf_flag got=%0b required 1", overflow_o); end
    tx_ready_i = 1'b1;
    wait_drain(200, "ovf");
    l = 24'($urandom()); r = 24'($urandom());
    strobe(l, r);
    add_pkt(8'h06, l, r);
    wait_drain(100, "ovf_after");
    checks += 2;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b required 1", overflow_o); end
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_len got=%0d required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got=%02h required %02h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] a0, a1, a2, b0, b1, b2, c0, c1, c2;
    logic [23:0] l0, r0, l1, r1;
    apply_reset();
    enable_i = 1'b1; tx_ready_i = 1'b1;
    a0 = 8'($urandom()); a1 = 8'($urandom()); a2 = 8'($urandom());
    b0 = 8'($urandom()); b1 = 8'($urandom()); b2 = 8'($urandom());
    c0 = 8'($urandom()); c1 = 8'($urandom()); c2 = 8'($urandom());
    l0 = 24'($urandom()); r0 = 24'($urandom()); l1 = 24'($urandom()); r1 = 24'($urandom());
    // After reset RSP wins the tie.
    run_rsp(a0, a1, a2, 1'b1, l0, r0);
    exp_q.push_back(a0); exp_q.push_back(a1); exp_q.push_back(a2);
    add_pkt(8'h00, l0, r0);
    wait_drain(100, "arb1");
    // Response alone, so RSP becomes the last grant.
    run_rsp(b0, b1, b2, 1'b0, l0, r0);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    wait_drain(100, "arb2");
    // Tie again: stream must now win.
    run_rsp(c0, c1, c2, 1'b1, l1, r1);
    add_pkt(8'h01, l1, r1);
    exp_q.push_back(c0); exp_q.push_back(c1); exp_q.push_back(c2);
    wait_drain(100, "arb3");
    checks++;
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL arb_len got=%0d required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL arb_byte%0d got=%02h required %02h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [23:0] l, r;
    apply_reset();
    enable_i = 1'b1; tx_ready_i = 1'b1;
    strobe(24'($urandom()), 24'($urandom()));
    while (cap_q.size() < 4 && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL rmid_timeout bytes=%0d required 4", cap_q.size()); end
    rst_i = 1'b1;
    tick();
    checks += 2;
    if (tx_valid_o !== 1'b0)   begin errors++; $display("FAIL rmid_tx_valid got=%0b required 0", tx_valid_o); end
    if (fifo_level_o !== 3'd0) begin errors++; $display("FAIL rmid_level got=%0d required 0", fifo_level_o); end
    rst_i = 1'b0;
    cap_q.delete(); exp_q.delete();
    l = 24'($urandom()); r = 24'($urandom());
    strobe(l, r);
    add_pkt(8'h00, l, r);
    wait_drain(100, "rmid");
    checks++;
    if (cap_q.size() !== exp_q.size()) begin errors++; $display("FAIL rmid_len got=%0d required %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_byte%0d got=%02h required %02h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_decim();
    test_random();
    test_backpressure();
    test_overflow();
    test_arbitration();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
